uart_fifo: RTL and testbench
============================

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter FREQ_MHZ, default 60, meaning system clock frequency in MHz.
REQ-002 SHALL have parameter BAUDS, default 115200, meaning reset-time baud rate.
REQ-003 SHALL have parameter TX_DEPTH, default 16, meaning TX FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter RX_DEPTH, default 16, meaning RX FIFO entries (power of 2, >=2).
REQ-005 SHALL have port clk, input, 1, meaning system clock; all state on rising edge.
REQ-006 SHALL have port resetq, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-007 SHALL have ports rstrb, wstrb, sel_dat, sel_cntl, all inputs, 1 bit each, meaning read strobe, write strobe, data-register select and control-register select.
REQ-008 SHALL have port wdata, input, 32, meaning write data.
REQ-009 SHALL have port rdata, output, 32, meaning combinational read data.
REQ-010 SHALL have ports RXD (input, 1, serial in) and TXD (output, 1, serial out).
REQ-011 SHALL have port brk, output, 1, meaning a one-cycle pulse on receipt of byte 0x03.

Function
REQ-012 SHALL hold a 16-bit divisor DIV = FREQ_MHZ*1000000/BAUDS at reset; one bit time = DIV clocks; a written DIV below 2 SHALL be clamped to 2.
REQ-013 SHALL, on sel_dat&&wstrb, push wdata[7:0] into the TX FIFO; when the TX FIFO is full the byte SHALL be dropped silently.
REQ-014 SHALL, on sel_dat&&rstrb with the RX FIFO non-empty, pop one byte; a read of an empty FIFO SHALL NOT pop.
REQ-015 SHALL drive rdata as follows: with sel_dat, {22'b0, tx_full, rx_valid, rx_head[7:0]}; with sel_cntl, {DIV[15:0], 3'b0, tx_empty, parity_err, overrun, tx_full, rx_valid, 8'b0}; otherwise 0. tx_empty SHALL mean FIFO empty and shifter idle.
REQ-016 SHALL, on sel_cntl&&wstrb, load DIV from wdata[15:0] when wdata[17]=1 and clear the overrun and parity_err sticky bits when wdata[16]=1.
REQ-017 SHALL apply a DIV change at the next frame start of each direction, never mid-frame.
REQ-018 SHALL run the TX FSM through IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> IDLE; TXD SHALL be 1 in IDLE and STOP, and 0 in START.
REQ-019 SHALL start a frame from IDLE when the TX FIFO is non-empty, with TXD falling within 2 clocks of the push; back-to-back bytes SHALL add no idle bit.
REQ-020 SHALL pass RXD through a 2-flop synchronizer; the RX FSM SHALL move IDLE -> START on a falling edge.
REQ-021 SHALL, in START, sample at DIV/2 and return to IDLE if the line is high (glitch); otherwise go to DATA, sample 8 bits at DIV intervals, go to [PARITY], then STOP.
REQ-022 SHALL, in STOP, discard the byte and push nothing when the sampled stop bit is 0 (framing error).
REQ-023 SHALL, on a valid stop with the RX FIFO full, drop the byte and set overrun; a simultaneous pop and push on a full FIFO SHALL succeed without overrun.
REQ-024 SHALL pulse brk high for exactly one clock when a valid frame with byte 0x03 completes, regardless of FIFO state; brk SHALL NOT reset any state.
REQ-025 SHALL wrap FIFO pointers modulo depth, with full and empty distinguished by an extra pointer bit.

Reset
REQ-026 SHALL, while resetq=0, force TXD=1, brk=0, both FSMs to IDLE, both FIFOs empty, overrun=0, parity_err=0 and DIV to its reset value.
REQ-027 SHALL, on reset mid-frame, abort the frame immediately without a partial byte entering either FIFO.

Configuration
REQ-028 SHALL, with macro UART_FIFO_PARITY_EN defined, insert one even-parity bit after the data bits on TX and check it on RX; on mismatch the RX byte SHALL still be pushed and parity_err set (sticky).
REQ-029 SHALL, without UART_FIFO_PARITY_EN, omit the PARITY state (10-bit frames); parity_err SHALL read 0.

Verification
REQ-030 SHALL cover: reset, then write 0x55 -> TXD frame 0,1,0,1,0,1,0,1,0,1 with each bit lasting DIV clocks, then tx_empty=1.
REQ-031 SHALL cover: push TX_DEPTH+1 bytes while the shifter is busy -> tx_full=1, last byte dropped, first TX_DEPTH bytes sent in order.
REQ-032 SHALL cover: drive RX_DEPTH+1 frames with no reads -> overrun=1, reads return the first RX_DEPTH bytes, then rx_valid=0.
REQ-033 SHALL cover: RXD low pulse of DIV/4 clocks -> nothing received; frame with stop bit 0 -> nothing pushed.
REQ-034 SHALL cover: receive 0x03 -> brk high for exactly 1 clock and 0x03 readable from the RX FIFO.
REQ-035 SHALL cover: write DIV=20 mid-transmit -> current frame keeps the old timing and the next frame uses 20 clocks per bit; with UART_FIFO_PARITY_EN, a bad parity bit on 0x07 -> parity_err=1.

Source files
------------

// File: rtl/uart_fifo.sv
// UART with TX/RX byte FIFOs, runtime baud divisor and break-byte detect.
// Define UART_FIFO_PARITY_EN for an even-parity bit after the data bits.
//
//   state    | meaning (shared by TX and RX FSMs)
//   S_IDLE   | line idle, waiting for a byte (TX) or a falling edge (RX)
//   S_START  | start bit (RX: validated at half a bit time)
//   S_DATA   | eight data bits, LSB first
//   S_PARITY | even-parity bit, reachable only with parity enabled
//   S_STOP   | stop bit (RX: frame accepted or discarded here)
module uart_fifo #(
  parameter int FREQ_MHZ = 60,
  parameter int BAUDS    = 115200,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        rstrb,
  input  logic        wstrb,
  input  logic        sel_dat,
  input  logic        sel_cntl,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        RXD,
  output logic        TXD,
  output logic        brk
);

  localparam int DIV_CALC = FREQ_MHZ * 1000000 / BAUDS;
  localparam logic [15:0] DIV_RST = (DIV_CALC < 2) ? 16'd2 : 16'(DIV_CALC);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

`ifdef UART_FIFO_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d, perr_q, perr_d;

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic         tx_full, tx_fifo_empty, tx_push, tx_load, tx_empty, tx_tc;
  logic [7:0]   tx_head;
  logic [2:0]   tx_st_q, tx_st_d, tx_bit_q, tx_bit_d;
  logic [15:0]  tx_cnt_q, tx_cnt_d, tx_bdiv_q, tx_bdiv_d;
  logic [7:0]   tx_sh_q, tx_sh_d;
  logic         tx_par_q, tx_par_d, txd_q, txd_d;

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic         rx_full, rx_fifo_empty, rx_valid, rx_push, rx_pop, rx_wr, rx_perr, rx_tc;
  logic [7:0]   rx_head;
  logic         rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  logic [2:0]   rx_st_q, rx_st_d, rx_bit_q, rx_bit_d;
  logic [15:0]  rx_cnt_q, rx_cnt_d, rx_bdiv_q, rx_bdiv_d;
  logic [7:0]   rx_sh_q, rx_sh_d;
  logic         rx_par_q, rx_par_d, brk_q, brk_d;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:18];

  // FIFO status: the extra pointer bit separates full from empty
  assign tx_fifo_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[TAW] != tx_rp_q[TAW]) && (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
  assign tx_head  = tx_mem[tx_rp_q[TAW-1:0]];
  assign tx_push  = sel_dat && wstrb && !tx_full;
  assign tx_empty = tx_fifo_empty && (tx_st_q == S_IDLE);
  assign tx_tc    = (tx_cnt_q == 16'd0);

  assign rx_fifo_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[RAW] != rx_rp_q[RAW]) && (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
  assign rx_valid = !rx_fifo_empty;
  assign rx_head  = rx_mem[rx_rp_q[RAW-1:0]];
  assign rx_pop   = sel_dat && rstrb && rx_valid;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign rx_tc    = (rx_cnt_q == 16'd0);

  assign TXD = txd_q;
  assign brk = brk_q;

  always_comb begin
    rdata = 32'd0;
    if (sel_dat)
      rdata = {22'd0, tx_full, rx_valid, rx_head};
    else if (sel_cntl)
      rdata = {div_q, 3'd0, tx_empty, perr_q, ovr_q, tx_full, rx_valid, 8'd0};
  end

  always_comb begin
    div_d  = div_q;
    ovr_d  = ovr_q;
    perr_d = perr_q;
    if (sel_cntl && wstrb) begin
      if (wdata[17]) div_d = (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
      if (wdata[16]) begin
        ovr_d  = 1'b0;
        perr_d = 1'b0;
      end
    end
    if (rx_push && !rx_wr) ovr_d = 1'b1;
    if (rx_perr) perr_d = 1'b1;
    tx_wp_d = tx_wp_q + (TAW+1)'(tx_push);
    tx_rp_d = tx_rp_q + (TAW+1)'(tx_load);
    rx_wp_d = rx_wp_q + (RAW+1)'(rx_wr);
    rx_rp_d = rx_rp_q + (RAW+1)'(rx_pop);
  end

  // The bit period is latched per frame so a divisor write never disturbs a frame in flight
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bdiv_d = tx_bdiv_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_load   = 1'b0;
    if (tx_st_q != S_IDLE)
      tx_cnt_d = tx_tc ? tx_bdiv_q - 16'd1 : tx_cnt_q - 16'd1;
    case (tx_st_q)
      S_IDLE:  tx_load = !tx_fifo_empty;
      S_START: if (tx_tc) begin
        tx_st_d  = S_DATA;
        tx_bit_d = 3'd0;
      end
      S_DATA: if (tx_tc) begin
        if (tx_bit_q == 3'd7) begin
          tx_st_d = PAR_EN ? S_PARITY : S_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        end
      end
      S_PARITY: if (tx_tc) tx_st_d = S_STOP;
      S_STOP: if (tx_tc) begin
        tx_st_d = S_IDLE;
        tx_load = !tx_fifo_empty;
      end
      default: tx_st_d = S_IDLE;
    endcase
    if (tx_load) begin
      tx_st_d   = S_START;
      tx_cnt_d  = div_q - 16'd1;
      tx_bdiv_d = div_q;
      tx_sh_d   = tx_head;
      tx_par_d  = ^tx_head;
    end
    case (tx_st_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = tx_sh_d[0];
      S_PARITY: txd_d = tx_par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_s1_d   = RXD;
    rx_s2_d   = rx_s1_q;
    rx_s3_d   = rx_s2_q;
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bdiv_d = rx_bdiv_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_par_d  = rx_par_q;
    rx_push   = 1'b0;
    rx_perr   = 1'b0;
    brk_d     = 1'b0;
    if (rx_st_q != S_IDLE)
      rx_cnt_d = rx_tc ? rx_bdiv_q - 16'd1 : rx_cnt_q - 16'd1;
    case (rx_st_q)
      S_IDLE: if (rx_s3_q && !rx_s2_q) begin
        rx_st_d   = S_START;
        rx_bdiv_d = div_q;
        rx_cnt_d  = {1'b0, div_q[15:1]} - 16'd1;
      end
      S_START: if (rx_tc) begin
        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        rx_bit_d = 3'd0;
      end
      S_DATA: if (rx_tc) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = PAR_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_tc) begin
        rx_par_d = rx_s2_q;
        rx_st_d  = S_STOP;
      end
      S_STOP: if (rx_tc) begin
        rx_st_d = S_IDLE;
        if (rx_s2_q) begin
          rx_push = 1'b1;
          brk_d   = (rx_sh_q == 8'h03);
          rx_perr = PAR_EN && ((^rx_sh_q) != rx_par_q);
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= wdata[7:0];
    if (rx_wr)   rx_mem[rx_wp_q[RAW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      div_q     <= DIV_RST;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= 16'd0;
      tx_bdiv_q <= DIV_RST;
      tx_bit_q  <= 3'd0;
      tx_sh_q   <= 8'd0;
      tx_par_q  <= 1'b0;
      txd_q     <= 1'b1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_s3_q   <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= 16'd0;
      rx_bdiv_q <= DIV_RST;
      rx_bit_q  <= 3'd0;
      rx_sh_q   <= 8'd0;
      rx_par_q  <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bdiv_q <= tx_bdiv_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      txd_q     <= txd_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_s3_q   <= rx_s3_d;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bdiv_q <= rx_bdiv_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_par_q  <= rx_par_d;
      brk_q     <= brk_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: serial line models on both pins, queue reference model.
// Runs with 16 clocks per bit and 4-entry FIFOs to keep frames short.
module tb_uart_fifo;

  localparam int DIV0  = 16;
  localparam int TDEP  = 4;
  localparam int RDEP  = 4;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        rstrb = 1'b0, wstrb = 1'b0, sel_dat = 1'b0, sel_cntl = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        RXD = 1'b1;
  logic        TXD, brk;

  uart_fifo #(.FREQ_MHZ(2), .BAUDS(125000), .TX_DEPTH(TDEP), .RX_DEPTH(RDEP)) dut (
    .clk(clk), .resetq(resetq), .rstrb(rstrb), .wstrb(wstrb), .sel_dat(sel_dat),
    .sel_cntl(sel_cntl), .wdata(wdata), .rdata(rdata), .RXD(RXD), .TXD(TXD), .brk(brk)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int brk_cnt = 0;
  logic [7:0] tx_got[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_model[$];

  always @(negedge clk) if (brk === 1'b1) brk_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input bit dat, input logic [31:0] d);
    @(negedge clk);
    sel_dat = dat; sel_cntl = !dat; wstrb = 1'b1; wdata = d;
    @(negedge clk);
    wstrb = 1'b0; sel_dat = 1'b0; sel_cntl = 1'b0;
  endtask

  task automatic rd_reg(input bit dat, output logic [31:0] v);
    @(negedge clk);
    sel_dat = dat; sel_cntl = !dat;
    #1 v = rdata;
    sel_dat = 1'b0; sel_cntl = 1'b0;
  endtask

  task automatic rx_pop(output logic [31:0] v);
    @(negedge clk);
    sel_dat = 1'b1;
    #1 v = rdata;
    rstrb = 1'b1;
    @(negedge clk);
    rstrb = 1'b0; sel_dat = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    RXD = b;
    repeat (DIV0) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic par_bad);
    @(negedge clk);
    drive_bit(1'b0);
    for (int j = 0; j < 8; j++) drive_bit(b[j]);
`ifdef UART_FIFO_PARITY_EN
    drive_bit((^b) ^ par_bad);
`else
    if (par_bad) RXD = 1'b1;
`endif
    drive_bit(stop_bit);
    RXD = 1'b1;
  endtask

  task automatic wait_low(output int lat);
    lat = 0;
    while (TXD !== 1'b0 && lat < 60 * DIV0) begin
      @(negedge clk);
      lat++;
    end
    chk("txd_fall", TXD, 1'b0);
  endtask

  // Frame 0,1,0,1,... of byte 0x55: each of the first nine levels must last div clocks
  task automatic measure_55(input int div);
    for (int r = 0; r < 9; r++) begin
      int cnt;
      logic lvl;
      lvl = r[0];
      cnt = 1;
      @(negedge clk);
      while (TXD === lvl && cnt < 4 * div) begin
        cnt++;
        @(negedge clk);
      end
      chk($sformatf("bit%0d_len", r), cnt, div);
    end
  endtask

  task automatic capture_tx(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      logic [7:0] b;
      w = 0;
      while (TXD !== 1'b0 && w < 60 * DIV0) begin
        @(negedge clk);
        w++;
      end
      if (TXD !== 1'b0) begin
        chk("tx_frame_timeout", TXD, 1'b0);
        return;
      end
      repeat (DIV0 / 2) @(negedge clk);
      b = 8'd0;
      for (int j = 0; j < 8; j++) begin
        repeat (DIV0) @(negedge clk);
        b[j] = TXD;
      end
`ifdef UART_FIFO_PARITY_EN
      repeat (DIV0) @(negedge clk);
      chk("tx_parity", TXD, ^b);
`endif
      repeat (DIV0) @(negedge clk);
      chk("tx_stop", TXD, 1'b1);
      tx_got.push_back(b);
    end
  endtask

  task automatic cmp_tx();
    chk("tx_count", tx_got.size(), tx_exp.size());
    while (tx_got.size() > 0 && tx_exp.size() > 0)
      chk("tx_byte", tx_got.pop_front(), tx_exp.pop_front());
    tx_got.delete();
    tx_exp.delete();
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    int lat, k, bc, brk_exp, lows;
    logic ovr_exp;

    repeat (3) @(negedge clk);
    chk("rst_txd", TXD, 1'b1);
    chk("rst_brk", brk, 1'b0);
    resetq = 1'b1;
    rd_reg(0, v);
    chk("rst_cntl", v, 32'h0010_1000);
    rd_reg(1, v);
    chk("rst_dat_flags", v[9:8], 2'b00);

    // single 0x55 frame: latency, bit timing, idle afterwards
    bus_wr(1, 32'h55);
    wait_low(lat);
    chk("tx_start_lat", lat <= 2, 1'b1);
    measure_55(DIV0);
    repeat (DIV0 + 2) @(negedge clk);
    rd_reg(0, v);
    chk("tx_empty_after", v[12], 1'b1);
    chk("txd_idle", TXD, 1'b1);

    bus_wr(0, 32'h0002_0001);
    rd_reg(0, v);
    chk("div_clamp", v[31:16], 16'd2);
    bus_wr(0, 32'h0002_0000 | DIV0);

    // TX overflow: one byte in the shifter, then TDEP+1 more pushes
    fork
      capture_tx(TDEP + 1);
      begin
        b = 8'($urandom);
        bus_wr(1, {24'd0, b});
        tx_exp.push_back(b);
        repeat (3) @(negedge clk);
        for (int i = 0; i < TDEP + 1; i++) begin
          b = 8'($urandom);
          bus_wr(1, {24'd0, b});
          if (i < TDEP) tx_exp.push_back(b);
        end
        rd_reg(1, v);
        chk("tx_full", v[9], 1'b1);
      end
    join
    cmp_tx();

    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, TDEP);
      fork
        capture_tx(k);
        for (int i = 0; i < k; i++) begin
          b = 8'($urandom);
          tx_exp.push_back(b);
          bus_wr(1, {24'd0, b});
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      join
      cmp_tx();
    end

    // divisor change mid-frame takes effect on the following frame only
    fork
      begin
        wait_low(lat);
        measure_55(DIV0);
        wait_low(lat);
        measure_55(20);
      end
      begin
        bus_wr(1, 32'h55);
        bus_wr(1, 32'h55);
        repeat (40) @(negedge clk);
        bus_wr(0, 32'h0002_0014);
        rd_reg(0, v);
        chk("div_rd", v[31:16], 16'd20);
      end
    join
    repeat (30) @(negedge clk);
    bus_wr(0, 32'h0002_0000 | DIV0);

    // RX overflow
    ovr_exp = 1'b0;
    bc = brk_cnt;
    brk_exp = 0;
    for (int i = 0; i < RDEP + 1; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, 1'b0);
      if (b == 8'h03) brk_exp++;
      if (rx_model.size() < RDEP) rx_model.push_back(b);
      else ovr_exp = 1'b1;
    end
    rd_reg(0, v);
    chk("rx_overrun", v[10], ovr_exp);
    chk("rx_valid_full", v[8], 1'b1);
    while (rx_model.size() > 0) begin
      rx_pop(v);
      chk("rx_byte_ovr", v[7:0], rx_model.pop_front());
    end
    rd_reg(1, v);
    chk("rx_drained", v[8], 1'b0);
    chk("brk_ovr", brk_cnt - bc, brk_exp);
    bus_wr(0, 32'h0001_0000);
    rd_reg(0, v);
    chk("ovr_clear", v[10], 1'b0);

    // start-bit glitch and framing error
    @(negedge clk);
    RXD = 1'b0;
    repeat (DIV0 / 4) @(negedge clk);
    RXD = 1'b1;
    repeat (3 * DIV0) @(negedge clk);
    rd_reg(1, v);
    chk("glitch_rx_valid", v[8], 1'b0);
    bc = brk_cnt;
    send_rx(8'h03, 1'b0, 1'b0);
    repeat (2 * DIV0) @(negedge clk);
    rd_reg(1, v);
    chk("frame_err_valid", v[8], 1'b0);
    chk("frame_err_brk", brk_cnt - bc, 0);

    bc = brk_cnt;
    send_rx(8'h03, 1'b1, 1'b0);
    chk("brk_pulse", brk_cnt - bc, 1);
    rx_pop(v);
    chk("brk_byte", v[8:0], 9'h103);

    bc = brk_cnt;
    brk_exp = 0;
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, RDEP);
      for (int i = 0; i < k; i++) begin
        b = (($urandom % 4) == 0) ? 8'h03 : 8'($urandom);
        send_rx(b, 1'b1, 1'b0);
        if (b == 8'h03) brk_exp++;
        rx_model.push_back(b);
      end
      while (rx_model.size() > 0) begin
        rx_pop(v);
        chk("rx_byte", v[8:0], {1'b1, rx_model.pop_front()});
      end
    end
    chk("brk_count", brk_cnt - bc, brk_exp);
    rd_reg(0, v);
    chk("perr_clean", v[11], 1'b0);

`ifdef UART_FIFO_PARITY_EN
    send_rx(8'h07, 1'b1, 1'b1);
    rd_reg(0, v);
    chk("parity_err", v[11], 1'b1);
    rx_pop(v);
    chk("parity_byte", v[7:0], 8'h07);
    bus_wr(0, 32'h0001_0000);
    rd_reg(0, v);
    chk("parity_clear", v[11], 1'b0);
`else
    send_rx(8'h07, 1'b1, 1'b1);
    rd_reg(0, v);
    chk("parity_err_zero", v[11], 1'b0);
    rx_pop(v);
    chk("nopar_byte", v[7:0], 8'h07);
`endif

    // reset in the middle of TX and RX frames
    bus_wr(1, 32'hA5);
    bus_wr(1, 32'h5A);
    @(negedge clk);
    RXD = 1'b0;
    repeat (3 * DIV0) @(negedge clk);
    RXD = 1'b1;
    repeat (5) @(negedge clk);
    resetq = 1'b0;
    #1;
    chk("rst_mid_txd", TXD, 1'b1);
    chk("rst_mid_brk", brk, 1'b0);
    @(negedge clk);
    resetq = 1'b1;
    lows = 0;
    for (int i = 0; i < 12 * DIV0; i++) begin
      @(negedge clk);
      if (TXD !== 1'b1) lows++;
    end
    chk("rst_mid_quiet", lows, 0);
    rd_reg(0, v);
    chk("rst_mid_cntl", v, 32'h0010_1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
